// File: rtl/game_pkg.sv
// Shared game constants: screen size, alien sprite bitmap and FSM state encodings
// used by the enemy renderers.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Rows 0..7 from MSB down; within a row bit 7 is the leftmost column.
  localparam logic [63:0] SPRITE_PATTERN = 64'h3C7E_FFCF_FF24_5AA5;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE    = 3'd0;
  localparam fsm_state_t ST_MARCH_R = 3'd1;
  localparam fsm_state_t ST_MARCH_L = 3'd2;
  localparam fsm_state_t ST_DROP_R  = 3'd3;
  localparam fsm_state_t ST_DROP_L  = 3'd4;
  localparam fsm_state_t ST_CLEARED = 3'd5;
  localparam fsm_state_t ST_INVADED = 3'd6;

  function automatic logic sprite_bit(input logic [2:0] oy, input logic [2:0] ox);
    logic [5:0] idx;
    idx = ~{oy, ox};
    return SPRITE_PATTERN[idx];
  endfunction

endpackage

// File: rtl/enemy_sprite_rom.sv
// Sprite lookup: scaled pixel offset inside one alien -> pattern bit.
module enemy_sprite_rom
  import game_pkg::*;
#(
  parameter int SCALE = 3,
  parameter int OFF_W = 5
) (
  input  logic [OFF_W-1:0] off_x_i,
  input  logic [OFF_W-1:0] off_y_i,
  output logic             bit_o
);

  logic [2:0] ox;
  logic [2:0] oy;

  assign ox    = 3'(off_x_i / OFF_W'(SCALE));
  assign oy    = 3'(off_y_i / OFF_W'(SCALE));
  assign bit_o = sprite_bit(oy, ox);

endmodule

// File: rtl/enemy_formation.sv
// One row of scaled aliens marching across the VGA field, with bullet
// collision, per-enemy alive bits and a registered RGB pixel output.
//
// state   | meaning
// IDLE    | waiting for start, nothing drawn
// MARCH_R | moving right on each march step
// MARCH_L | moving left on each march step
// DROP_R  | hit right edge, drop on next step then go left
// DROP_L  | hit left edge, drop on next step then go right
// CLEARED | all enemies dead, frozen
// INVADED | formation reached the bottom, frozen
module enemy_formation
  import game_pkg::*;
#(
  parameter int          N_ENEMIES = 8,
  parameter int          SCALE     = 3,
  parameter int          SPACING   = 32,
  parameter int          STEP_X    = 2,
  parameter int          STEP_DOWN = 8,
  parameter int          FRAME_DIV = 4,
  parameter int          START_X   = 16,
  parameter int          START_Y   = 32,
  parameter int          LOSE_Y    = 440,
  parameter logic [23:0] COLOR     = 24'hFF0000,
  localparam int         IDX_W     = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 frame_tick_i,
  input  logic [9:0]           h_counter_i,
  input  logic [9:0]           v_counter_i,
  input  logic [9:0]           bullet_x_i,
  input  logic [9:0]           bullet_y_i,
  input  logic                 bullet_valid_i,
  output logic [7:0]           r_o,
  output logic [7:0]           g_o,
  output logic [7:0]           b_o,
  output logic                 pixel_on_o,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     hit_index_o,
  output logic [N_ENEMIES-1:0] alive_mask_o,
  output logic [9:0]           form_x_o,
  output logic [9:0]           form_y_o,
  output logic                 cleared_o,
  output logic                 invaded_o
);

  localparam int          SPR    = 8 * SCALE;
  localparam int          OFF_W  = $clog2(SPR);
  localparam int          DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [10:0] SPR_W  = 11'(SPR);
  localparam logic [10:0] STEP_W = 11'(STEP_X);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - 1);
  localparam logic [10:0] LOSE_W = 11'(LOSE_Y);

  fsm_state_t             state_q, state_d;
  logic [N_ENEMIES-1:0]   alive_q, alive_d;
  logic [9:0]             form_x_q, form_x_d;
  logic [9:0]             form_y_q, form_y_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic                   pix_on_q;
  logic [7:0]             r_q, g_q, b_q;

  logic [10:0]            fx, fy, bx, by, hx, hy;
  logic [10:0]            ex [N_ENEMIES];
  logic [10:0]            left_edge, right_edge;
  logic                   active, step;
  logic                   kill;
  logic [IDX_W-1:0]       kill_idx;
  logic [N_ENEMIES-1:0]   kill_mask;
  logic                   draw_hit, draw_row, rom_bit, pix;
  logic [OFF_W-1:0]       rel_x, rel_y;

  assign fx = {1'b0, form_x_q};
  assign fy = {1'b0, form_y_q};
  assign bx = {1'b0, bullet_x_i};
  assign by = {1'b0, bullet_y_i};
  assign hx = {1'b0, h_counter_i};
  assign hy = {1'b0, v_counter_i};

  assign active = state_q inside {ST_MARCH_R, ST_MARCH_L, ST_DROP_R, ST_DROP_L};
  assign step   = frame_tick_i && (div_q == DIV_W'(FRAME_DIV - 1));

  always_comb begin
    for (int i = 0; i < N_ENEMIES; i++) ex[i] = fx + 11'(i * SPACING);
  end

  // Edges follow the live extent only, so killing end enemies lets the row travel further.
  always_comb begin
    left_edge  = fx;
    right_edge = fx + SPR_W - 11'd1;
    for (int i = N_ENEMIES - 1; i >= 0; i--) if (alive_q[i]) left_edge = ex[i];
    for (int i = 0; i < N_ENEMIES; i++) if (alive_q[i]) right_edge = ex[i] + SPR_W - 11'd1;
  end

  // Descending scan so the lowest index overwrites and wins.
  always_comb begin
    kill      = 1'b0;
    kill_idx  = '0;
    kill_mask = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (bullet_valid_i && alive_q[i] && bx >= ex[i] && bx < ex[i] + SPR_W &&
          by >= fy && by < fy + SPR_W) begin
        kill         = 1'b1;
        kill_idx     = IDX_W'(i);
        kill_mask    = '0;
        kill_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    form_x_d  = form_x_q;
    form_y_d  = form_y_q;
    div_d     = div_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    if (start_i) begin
      state_d  = ST_MARCH_R;
      alive_d  = '1;
      form_x_d = 10'(START_X);
      form_y_d = 10'(START_Y);
      div_d    = '0;
    end else if (active) begin
      if (frame_tick_i) div_d = step ? '0 : div_q + 1'b1;
      if (kill) begin
        alive_d   = alive_q & ~kill_mask;
        hit_d     = 1'b1;
        hit_idx_d = kill_idx;
      end
      if (alive_q == '0) begin
        state_d = ST_CLEARED;
      end else if (fy + SPR_W > LOSE_W) begin
        state_d = ST_INVADED;
      end else if (step) begin
        case (state_q)
          ST_MARCH_R: begin
            if (right_edge + STEP_W > X_MAX) state_d = ST_DROP_R;
            else form_x_d = form_x_q + 10'(STEP_X);
          end
          ST_MARCH_L: begin
            if (left_edge < STEP_W) state_d = ST_DROP_L;
            else form_x_d = form_x_q - 10'(STEP_X);
          end
          ST_DROP_R: begin
            form_y_d = form_y_q + 10'(STEP_DOWN);
            state_d  = ST_MARCH_L;
          end
          ST_DROP_L: begin
            form_y_d = form_y_q + 10'(STEP_DOWN);
            state_d  = ST_MARCH_R;
          end
          default: ;
        endcase
      end
    end
  end

  // Spacing keeps aliens disjoint, so at most one matches and a single ROM suffices.
  always_comb begin
    draw_hit = 1'b0;
    rel_x    = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (alive_q[i] && hx >= ex[i] && hx < ex[i] + SPR_W) begin
        draw_hit = 1'b1;
        rel_x    = OFF_W'(hx - ex[i]);
      end
    end
  end

  assign draw_row = (hy >= fy) && (hy < fy + SPR_W);
  assign rel_y    = OFF_W'(hy - fy);

  enemy_sprite_rom #(
    .SCALE (SCALE),
    .OFF_W (OFF_W)
  ) u_rom (
    .off_x_i (rel_x),
    .off_y_i (rel_y),
    .bit_o   (rom_bit)
  );

  assign pix = draw_hit && draw_row && rom_bit && (state_q != ST_IDLE) &&
               (hx < 11'(SCREEN_W)) && (hy < 11'(SCREEN_H));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      alive_q   <= '0;
      form_x_q  <= 10'(START_X);
      form_y_q  <= 10'(START_Y);
      div_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      pix_on_q  <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      form_x_q  <= form_x_d;
      form_y_q  <= form_y_d;
      div_q     <= div_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      pix_on_q  <= pix;
      r_q       <= pix ? COLOR[23:16] : 8'h00;
      g_q       <= pix ? COLOR[15:8]  : 8'h00;
      b_q       <= pix ? COLOR[7:0]   : 8'h00;
    end
  end

  assign r_o          = r_q;
  assign g_o          = g_q;
  assign b_o          = b_q;
  assign pixel_on_o   = pix_on_q;
  assign hit_o        = hit_q;
  assign hit_index_o  = hit_idx_q;
  assign alive_mask_o = alive_q;
  assign form_x_o     = form_x_q;
  assign form_y_o     = form_y_q;
  assign cleared_o    = (state_q == ST_CLEARED);
  assign invaded_o    = (state_q == ST_INVADED);

endmodule

// File: tb/tb_enemy_formation.sv
// Directed bench for enemy_formation with default parameters.
module tb_enemy_formation;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i, frame_tick_i, bullet_valid_i;
  logic [9:0] h_counter_i, v_counter_i, bullet_x_i, bullet_y_i;
  logic [7:0] r_o, g_o, b_o;
  logic       pixel_on_o, hit_o, cleared_o, invaded_o;
  logic [2:0] hit_index_o;
  logic [7:0] alive_mask_o;
  logic [9:0] form_x_o, form_y_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  enemy_formation dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .frame_tick_i   (frame_tick_i),
    .h_counter_i    (h_counter_i),
    .v_counter_i    (v_counter_i),
    .bullet_x_i     (bullet_x_i),
    .bullet_y_i     (bullet_y_i),
    .bullet_valid_i (bullet_valid_i),
    .r_o            (r_o),
    .g_o            (g_o),
    .b_o            (b_o),
    .pixel_on_o     (pixel_on_o),
    .hit_o          (hit_o),
    .hit_index_o    (hit_index_o),
    .alive_mask_o   (alive_mask_o),
    .form_x_o       (form_x_o),
    .form_y_o       (form_y_o),
    .cleared_o      (cleared_o),
    .invaded_o      (invaded_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic march(input int steps);
    repeat (steps * 4) begin
      frame_tick_i = 1'b1;
      cyc();
    end
    frame_tick_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic shoot(input int x, input int y);
    bullet_x_i     = 10'(x);
    bullet_y_i     = 10'(y);
    bullet_valid_i = 1'b1;
    cyc();
    bullet_valid_i = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    h_counter_i = 10'(x);
    v_counter_i = 10'(y);
    cyc();
  endtask

  initial begin
    logic [7:0] exp_mask;
    int budget;
    reset_i = 1'b0;
    start_i = 1'b0;
    frame_tick_i = 1'b0;
    bullet_valid_i = 1'b0;
    bullet_x_i = '0;
    bullet_y_i = '0;
    h_counter_i = '0;
    v_counter_i = '0;
    #12;
    check("rst_alive", alive_mask_o, 8'h00);
    check("rst_fx", form_x_o, 16);
    check("rst_fy", form_y_o, 32);
    check("rst_pix", pixel_on_o, 0);
    check("rst_r", r_o, 0);
    check("rst_hit", hit_o, 0);
    check("rst_cleared", cleared_o, 0);
    check("rst_invaded", invaded_o, 0);
    reset_i = 1'b1;
    cyc();

    probe(22, 32);
    check("idle_pix", pixel_on_o, 0);

    pulse_start();
    check("start_alive", alive_mask_o, 8'hFF);
    check("start_fx", form_x_o, 16);
    check("start_fy", form_y_o, 32);

    frame_tick_i = 1'b1;
    repeat (3) cyc();
    frame_tick_i = 1'b0;
    check("div3_fx", form_x_o, 16);
    march(0);
    frame_tick_i = 1'b1;
    cyc();
    frame_tick_i = 1'b0;
    check("div4_fx", form_x_o, 18);

    probe(24, 32);
    check("pix_e0_r", r_o, 8'hFF);
    check("pix_e0_g", g_o, 8'h00);
    check("pix_e0_b", b_o, 8'h00);
    check("pix_e0_on", pixel_on_o, 1);
    probe(18, 32);
    check("pix_corner_on", pixel_on_o, 0);
    check("pix_corner_r", r_o, 8'h00);
    probe(24, 41);
    check("pix_row3_on", pixel_on_o, 0);
    probe(59, 32);
    check("pix_e1_on", pixel_on_o, 1);

    bullet_x_i = 10'(18 + 33);
    bullet_y_i = 10'(32 + 5);
    bullet_valid_i = 1'b1;
    cyc();
    check("hit1_pulse", hit_o, 1);
    check("hit1_idx", hit_index_o, 1);
    check("hit1_mask", alive_mask_o, 8'hFD);
    cyc();
    check("hit1_once", hit_o, 0);
    check("hit1_mask_hold", alive_mask_o, 8'hFD);
    bullet_valid_i = 1'b0;

    march(187);
    check("edge_fx", form_x_o, 392);
    march(1);
    check("edge_nomove_fx", form_x_o, 392);
    check("edge_nomove_fy", form_y_o, 32);
    march(1);
    check("drop_fy", form_y_o, 40);
    check("drop_fx", form_x_o, 392);
    march(1);
    check("left_fx", form_x_o, 390);

    pulse_start();
    check("restart_fx", form_x_o, 16);
    shoot(241, 34);
    check("kill7_hit", hit_o, 1);
    check("kill7_idx", hit_index_o, 7);
    check("kill7_mask", alive_mask_o, 8'h7F);
    march(204);
    check("short_edge_fx", form_x_o, 424);
    march(1);
    check("short_nomove_fx", form_x_o, 424);
    check("short_nomove_fy", form_y_o, 32);
    march(1);
    check("short_drop_fy", form_y_o, 40);

    pulse_start();
    shoot(40, 32);
    check("miss_x_hit", hit_o, 0);
    shoot(16, 56);
    check("miss_y_hit", hit_o, 0);
    check("miss_mask", alive_mask_o, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      shoot(16 + 32 * i + 23, 32 + 23);
      exp_mask = 8'hFF << (i + 1);
      check($sformatf("killall_hit%0d", i), hit_o, 1);
      check($sformatf("killall_idx%0d", i), hit_index_o, i);
      check($sformatf("killall_mask%0d", i), alive_mask_o, exp_mask);
    end
    check("cleared_early", cleared_o, 0);
    cyc();
    check("cleared_set", cleared_o, 1);
    check("cleared_hit_low", hit_o, 0);
    march(2);
    check("cleared_fx", form_x_o, 16);
    check("cleared_fy", form_y_o, 32);
    check("cleared_sticky", cleared_o, 1);
    probe(22, 32);
    check("cleared_pix", pixel_on_o, 0);

    pulse_start();
    check("rearm_mask", alive_mask_o, 8'hFF);
    check("rearm_cleared", cleared_o, 0);
    budget = 0;
    frame_tick_i = 1'b1;
    while (!invaded_o && budget < 60000) begin
      cyc();
      budget++;
    end
    frame_tick_i = 1'b0;
    check("invaded_set", invaded_o, 1);
    check("invaded_fy", form_y_o, 424);
    check("invaded_fx", form_x_o, 392);
    check("invaded_not_cleared", cleared_o, 0);
    march(2);
    check("invaded_frozen_fx", form_x_o, 392);
    check("invaded_frozen_fy", form_y_o, 424);
    probe(398, 424);
    check("invaded_draw", pixel_on_o, 1);

    pulse_start();
    march(3);
    check("mid_fx", form_x_o, 22);
    probe(28, 32);
    check("mid_pix", pixel_on_o, 1);
    #2 reset_i = 1'b0;
    #1;
    check("arst_pix", pixel_on_o, 0);
    check("arst_r", r_o, 8'h00);
    check("arst_mask", alive_mask_o, 8'h00);
    check("arst_fx", form_x_o, 16);
    check("arst_hit", hit_o, 0);
    reset_i = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
